stopwatch_lap: RTL

Parametrised BCD stopwatch with an internal tick prescaler, a configurable number of decimal digits and a lap memory with recall. It sits between the button synchronisers/edge detectors and the 7-segment decoders. It outputs the live count and one selected stored lap as packed BCD. It adds the following over the single-split timer:
- clear-while-stopped
- multi-entry lap storage
- cyclic recall
- sticky overflow indication

---
 rtl/stopwatch_lap.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// BCD stopwatch with tick prescaler, configurable digit count and a lap memory
// with cyclic recall and sticky overflow.
module stopwatch_lap #(
    parameter int unsigned FREQ_MHZ     = 50,
    parameter int unsigned TICK_MS      = 100,
    parameter int unsigned DIV_OVERRIDE = 0,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned LAP_DEPTH    = 4,
    localparam int unsigned IDX_W       = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int unsigned CNT_W       = $clog2(LAP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  lap,
    input  logic                  recall,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  tick,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   lap_bcd,
    output logic [IDX_W-1:0]      lap_idx,
    output logic [CNT_W-1:0]      lap_count,
    output logic                  lap_full
);

    localparam int unsigned DIV = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE : FREQ_MHZ * 1000 * TICK_MS;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned W   = 4 * DIGITS;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [W-1:0]     bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     mem_q [LAP_DEPTH];
    logic [W-1:0]     mem_d [LAP_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     lap_bcd_q, lap_bcd_d;
    logic             run_w, tick_w, capture, carry;

    assign run_w  = (state_q == ST_RUNNING);
    assign tick_w = run_w && (presc_q == PW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        if (start_stop) begin
            state_d = (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end
    end

    always_comb begin
        presc_d = '0;
        if (run_w && state_d == ST_RUNNING) begin
            presc_d = tick_w ? '0 : presc_q + PW'(1);
        end

        // Ripple-carry BCD increment; a carry out of the top digit is the wrap.
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        carry = tick_w;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (bcd_q[4*k +: 4] == 4'd9) begin
                    bcd_d[4*k +: 4] = '0;
                end else begin
                    bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            ovf_d = 1'b1;
        end

        capture = run_w && lap && (cnt_q < CNT_W'(LAP_DEPTH));
        mem_d   = mem_q;
        for (int unsigned e = 0; e < LAP_DEPTH; e++) begin
            if (capture && CNT_W'(e) == cnt_q) begin
                mem_d[e] = bcd_q;
            end
        end
        cnt_d = cnt_q + CNT_W'(capture);

        idx_d = idx_q;
        if (recall && cnt_q != '0) begin
            idx_d = (CNT_W'(idx_q) == cnt_q - CNT_W'(1)) ? '0 : idx_q + IDX_W'(1);
        end

        if (clr && !run_w) begin
            bcd_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
            idx_d = '0;
        end

        // Selected from next-state values so lap_bcd always agrees with lap_idx/lap_count.
        lap_bcd_d = '0;
        if (cnt_d != '0) begin
            for (int unsigned e = 0; e < LAP_DEPTH; e++) begin
                if (IDX_W'(e) == idx_d) begin
                    lap_bcd_d = mem_d[e];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STOPPED;
            presc_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            lap_bcd_q <= '0;
            for (int unsigned e = 0; e < LAP_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lap_bcd_q <= lap_bcd_d;
            mem_q     <= mem_d;
        end
    end

    assign bcd       = bcd_q;
    assign running   = run_w;
    assign tick      = tick_w;
    assign overflow  = ovf_q;
    assign lap_bcd   = lap_bcd_q;
    assign lap_idx   = idx_q;
    assign lap_count = cnt_q;
    assign lap_full  = (cnt_q == CNT_W'(LAP_DEPTH));

endmodule
